snake_grid_writer: RTL and testbench
====================================

Name: snake_grid_writer

Overview:
Game-logic writer for the 15x15 cell memory that the VGA controller scans and reads. On each game tick it advances the snake one cell and reads the target cell to detect collisions. It then writes the new head, clears the tail, and places food. After reset it clears the grid and draws the initial scene. It shares the memory's single x/y address port with the memory's readEnable/data_out read path.

Parameters:
MAX_LEN, 32, body buffer depth (power of 2); maximum snake length
LFSR_SEED, 8'hA5, food LFSR reset value (nonzero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick  in  1  one-cycle move request
dir  in  2  00 up, 01 right, 10 down, 11 left
rd_data  in  2  memory data_out; valid the cycle after rd_en
x_loc  out  5  cell column, 1..15
y_loc  out  5  cell row, 1..15
wr_data  out  2  cell code to write
wr_en  out  1  write strobe (one cycle per cell)
rd_en  out  1  read strobe; never high together with wr_en
busy  out  1  high in every state except IDLE and GAME_OVER
game_over  out  1  sticky until reset
score  out  8  foods eaten, saturating at 255

Behaviour:
- Cell codes: 00 world, 01 food, 10 snake, 11 reserved (treated as snake).
- All outputs are registered.
- Reset values while reset=0: wr_en=0, rd_en=0, x_loc=1, y_loc=1, wr_data=00, busy=0, game_over=0, score=0.
- Internal reset values: cur_dir=01, LFSR=LFSR_SEED, state=CLEAR.
- Reset asserted in any state aborts the operation the next cycle. No partial-write protection is needed.
- CLEAR: writes 00 to all 225 cells, one per cycle, in x-fastest order, (1,1) through (15,15).
- INIT_SNAKE: writes 10 to (6,8), (7,8), (8,8) over 3 cycles. The body buffer then holds tail=(6,8), head=(8,8), length=3.
- Then goes to PLACE_FOOD.
- PLACE_FOOD:
  - Candidate x=lfsr[3:0], y=lfsr[7:4]. If either is 0, step the LFSR and retry next cycle.
  - Otherwise assert rd_en, wait one cycle, sample rd_data.
  - If rd_data is 00: write 01, step the LFSR, go to IDLE. Otherwise step the LFSR and retry.
  - LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1, stepped only in PLACE_FOOD.
- IDLE: on tick=1, latch dir into cur_dir unless it is the exact reverse of cur_dir; a reversing dir is ignored and cur_dir is kept.
  - Compute next = head + delta.
  - If next x or y is 0 or 16, go to GAME_OVER (no memory access). Otherwise go to READ_NEXT.
  - A tick in any state other than IDLE is dropped; there is no queueing.
- READ_NEXT: drive next on x_loc/y_loc, rd_en=1. CHECK follows the next cycle and samples rd_data.
- CHECK:
  - rd_data 10 or 11: GAME_OVER. The tail cell counts as a collision.
  - rd_data 00 or 01: WRITE_HEAD, which writes 10 at next and pushes next into the body buffer.
- After WRITE_HEAD:
  - If the target was 01 and length<MAX_LEN: length++, score++, go to PLACE_FOOD with no tail clear.
  - If the target was 01 and length==MAX_LEN: score++, CLEAR_TAIL, then PLACE_FOOD.
  - If the target was 00: CLEAR_TAIL (writes 00 at tail, pops the buffer), then IDLE.
- Tick-to-IDLE latency for a plain move is 4 cycles: READ_NEXT, CHECK, WRITE_HEAD, CLEAR_TAIL.
- GAME_OVER: game_over=1, busy=0, no memory access. Exits only on reset.
- Body buffer: circular, 10-bit entries {x,y}, head/tail pointers wrap modulo MAX_LEN.
  - When full, a push is always paired with a pop in the same sequence; never push when full without a pop.

Decomposition:
- Package snake_pkg: cell codes (CELL_WORLD, CELL_FOOD, CELL_SNAKE), direction codes, GRID_MIN=1, GRID_MAX=15, initial snake coordinates, state enum.
- Sub-module snake_body_fifo: circular coordinate buffer with push, pop, head, tail, count, full, empty.

Test Plan:
- Reset held 2 cycles, then released -> exactly 225 wr_en pulses with wr_data=00 covering every cell once, then 10 written to (6,8),(7,8),(8,8), then one food write (01) at the first LFSR-derived empty cell; busy falls.
- Memory model and tick with dir=01 after init -> rd_en at (9,8), then 10 written at (9,8), then 00 written at (6,8); IDLE after 4 cycles; score=0.
- Food preloaded in the model at (9,8), tick dir=01 -> 10 written at (9,8), no tail clear, score=1, new 01 written at a cell whose model value was 00.
- Head at (15,8), cur_dir=01, tick -> game_over=1 next cycle, no rd_en or wr_en; further ticks ignored; reset clears it.
- After init, dir=11 (reverse) with tick -> move still goes right to (9,8). Tick asserted while busy -> dropped, only one move occurs.
- Model returns 10 at the next cell -> GAME_OVER with no write. Reset asserted mid-CLEAR -> CLEAR restarts at (1,1).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants, cell/direction codes, FSM state type and the food LFSR
// step used by the snake grid writer.
package snake_pkg;

  localparam logic [1:0] CELL_WORLD    = 2'b00;
  localparam logic [1:0] CELL_FOOD     = 2'b01;
  localparam logic [1:0] CELL_SNAKE    = 2'b10;
  localparam logic [1:0] CELL_RESERVED = 2'b11;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [4:0] GRID_MIN = 5'd1;
  localparam logic [4:0] GRID_MAX = 5'd15;

  localparam logic [4:0] INIT_X0  = 5'd6;
  localparam logic [4:0] INIT_Y   = 5'd8;
  localparam logic [1:0] INIT_LAST = 2'd2;

  typedef enum logic [3:0] {
    ST_CLEAR,
    ST_INIT_SNAKE,
    ST_PLACE_FOOD,
    ST_FOOD_READ,
    ST_FOOD_CHECK,
    ST_FOOD_WRITE,
    ST_IDLE,
    ST_READ_NEXT,
    ST_CHECK,
    ST_WRITE_HEAD,
    ST_CLEAR_TAIL,
    ST_GAME_OVER
  } state_e;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of {x,y} body coordinates: head is the newest push,
// tail the oldest entry; push and pop may occur in the same cycle.
module snake_body_fifo #(
  parameter int MAX_LEN = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [9:0]                 push_data_i,
  output logic [9:0]                 head_o,
  output logic [9:0]                 tail_o,
  output logic [$clog2(MAX_LEN):0]   count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(MAX_LEN);

  logic [9:0]    mem_q [MAX_LEN];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] head_ptr;
  logic [AW:0]   count_q;

  assign head_ptr = wr_ptr_q - 1'b1;
  assign head_o   = mem_q[head_ptr];
  assign tail_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign full_o   = (count_q == FULL_CNT);
  assign empty_o  = (count_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/snake_grid_writer.sv
// Snake game logic driving the shared x/y port of the 15x15 cell memory:
// clears and seeds the grid, then moves the snake and places food per tick.
module snake_grid_writer
  import snake_pkg::*;
#(
  parameter int         MAX_LEN   = 32,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] dir,
  input  logic [1:0] rd_data,
  output logic [4:0] x_loc,
  output logic [4:0] y_loc,
  output logic [1:0] wr_data,
  output logic       wr_en,
  output logic       rd_en,
  output logic       busy,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int CW = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  state_e      state_q;
  logic [4:0]  x_q, y_q, clr_x_q, clr_y_q, next_x_q, next_y_q;
  logic [1:0]  wr_data_q, cur_dir_q, init_idx_q;
  logic        wr_en_q, rd_en_q, busy_q, game_over_q, ate_q;
  logic [7:0]  score_q, lfsr_q;

  logic [9:0]    head_w, tail_w, push_data_d;
  logic [CW-1:0] count_w;
  logic          full_w, empty_w, push_d, pop_d, grow_d, off_grid_d;
  logic [1:0]    eff_dir_d;
  logic [4:0]    nx_d, ny_d, init_x_d, cand_x_d, cand_y_d;

  assign x_loc     = x_q;
  assign y_loc     = y_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign score     = score_q;

  assign init_x_d = INIT_X0 + {3'b000, init_idx_q};
  assign cand_x_d = {1'b0, lfsr_q[3:0]};
  assign cand_y_d = {1'b0, lfsr_q[7:4]};

  // A full buffer only accepts the new head when the tail leaves with it.
  assign grow_d      = ate_q && (count_w < MAX_CNT);
  assign pop_d       = (state_q == ST_WRITE_HEAD) && !grow_d && !empty_w;
  assign push_d      = ((state_q == ST_INIT_SNAKE) || (state_q == ST_WRITE_HEAD)) &&
                       (!full_w || pop_d);
  assign push_data_d = (state_q == ST_INIT_SNAKE) ? {init_x_d, INIT_Y} : {next_x_q, next_y_q};

  snake_body_fifo #(.MAX_LEN(MAX_LEN)) u_body (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (push_d),
    .pop_i       (pop_d),
    .push_data_i (push_data_d),
    .head_o      (head_w),
    .tail_o      (tail_w),
    .count_o     (count_w),
    .full_o      (full_w),
    .empty_o     (empty_w)
  );

  always_comb begin
    eff_dir_d = (dir == (cur_dir_q ^ 2'b10)) ? cur_dir_q : dir;
    nx_d = head_w[9:5];
    ny_d = head_w[4:0];
    case (eff_dir_d)
      DIR_UP:    ny_d = head_w[4:0] - 5'd1;
      DIR_RIGHT: nx_d = head_w[9:5] + 5'd1;
      DIR_DOWN:  ny_d = head_w[4:0] + 5'd1;
      default:   nx_d = head_w[9:5] - 5'd1;
    endcase
    off_grid_d = (nx_d < GRID_MIN) || (nx_d > GRID_MAX) ||
                 (ny_d < GRID_MIN) || (ny_d > GRID_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      x_q         <= GRID_MIN;
      y_q         <= GRID_MIN;
      wr_data_q   <= CELL_WORLD;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= 8'd0;
      cur_dir_q   <= DIR_RIGHT;
      lfsr_q      <= LFSR_SEED;
      clr_x_q     <= GRID_MIN;
      clr_y_q     <= GRID_MIN;
      init_idx_q  <= 2'd0;
      next_x_q    <= GRID_MIN;
      next_y_q    <= GRID_MIN;
      ate_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b1;
      case (state_q)
        ST_CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_data_q <= CELL_WORLD;
          x_q       <= clr_x_q;
          y_q       <= clr_y_q;
          if (clr_x_q == GRID_MAX) begin
            clr_x_q <= GRID_MIN;
            if (clr_y_q == GRID_MAX) state_q <= ST_INIT_SNAKE;
            else                     clr_y_q <= clr_y_q + 5'd1;
          end else begin
            clr_x_q <= clr_x_q + 5'd1;
          end
        end
        ST_INIT_SNAKE: begin
          wr_en_q    <= 1'b1;
          wr_data_q  <= CELL_SNAKE;
          x_q        <= init_x_d;
          y_q        <= INIT_Y;
          init_idx_q <= init_idx_q + 2'd1;
          if (init_idx_q == INIT_LAST) state_q <= ST_PLACE_FOOD;
        end
        ST_PLACE_FOOD: begin
          if (cand_x_d == 5'd0 || cand_y_d == 5'd0) begin
            lfsr_q <= lfsr_step(lfsr_q);
          end else begin
            x_q     <= cand_x_d;
            y_q     <= cand_y_d;
            rd_en_q <= 1'b1;
            state_q <= ST_FOOD_READ;
          end
        end
        ST_FOOD_READ: state_q <= ST_FOOD_CHECK;
        ST_FOOD_CHECK: begin
          lfsr_q <= lfsr_step(lfsr_q);
          if (rd_data == CELL_WORLD) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= CELL_FOOD;
            state_q   <= ST_FOOD_WRITE;
          end else begin
            state_q <= ST_PLACE_FOOD;
          end
        end
        ST_FOOD_WRITE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (tick) begin
            cur_dir_q <= eff_dir_d;
            next_x_q  <= nx_d;
            next_y_q  <= ny_d;
            if (off_grid_d) begin
              game_over_q <= 1'b1;
              state_q     <= ST_GAME_OVER;
            end else begin
              busy_q  <= 1'b1;
              x_q     <= nx_d;
              y_q     <= ny_d;
              rd_en_q <= 1'b1;
              state_q <= ST_READ_NEXT;
            end
          end
        end
        ST_READ_NEXT: state_q <= ST_CHECK;
        ST_CHECK: begin
          // Snake and reserved codes both have the upper bit set.
          if (rd_data[1]) begin
            busy_q      <= 1'b0;
            game_over_q <= 1'b1;
            state_q     <= ST_GAME_OVER;
          end else begin
            ate_q     <= (rd_data == CELL_FOOD);
            wr_en_q   <= 1'b1;
            wr_data_q <= CELL_SNAKE;
            state_q   <= ST_WRITE_HEAD;
          end
        end
        ST_WRITE_HEAD: begin
          if (ate_q && score_q != 8'hFF) score_q <= score_q + 8'd1;
          if (grow_d) begin
            state_q <= ST_PLACE_FOOD;
          end else begin
            wr_en_q   <= 1'b1;
            wr_data_q <= CELL_WORLD;
            x_q       <= tail_w[9:5];
            y_q       <= tail_w[4:0];
            state_q   <= ST_CLEAR_TAIL;
          end
        end
        ST_CLEAR_TAIL: begin
          if (ate_q) begin
            state_q <= ST_PLACE_FOOD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_GAME_OVER: begin
          busy_q      <= 1'b0;
          game_over_q <= 1'b1;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_grid_writer.sv
// Bench for snake_grid_writer: registered cell memory around the DUT, a
// queue-based snake model predicting every read and write, directed and random ticks.
module tb_snake_grid_writer;

  localparam int MAX_LEN = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir = 2'd1;
  logic [1:0] rd_data = 2'd0;
  logic [4:0] x_loc, y_loc;
  logic [1:0] wr_data;
  logic       wr_en, rd_en, busy, game_over;
  logic [7:0] score;

  always #5 clk = ~clk;

  snake_grid_writer #(.MAX_LEN(MAX_LEN), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .rd_data(rd_data),
    .x_loc(x_loc), .y_loc(y_loc), .wr_data(wr_data), .wr_en(wr_en),
    .rd_en(rd_en), .busy(busy), .game_over(game_over), .score(score)
  );

  // Cell memory the DUT talks to; data_out is valid the cycle after rd_en.
  logic [1:0] mem [16][16];
  logic       pre_en = 1'b0;
  logic [4:0] pre_x = 5'd0, pre_y = 5'd0;
  logic [1:0] pre_d = 2'd0;

  always @(posedge clk) begin
    if (rd_en)  rd_data <= mem[x_loc[3:0]][y_loc[3:0]];
    if (wr_en)  mem[x_loc[3:0]][y_loc[3:0]] <= wr_data;
    if (pre_en) mem[pre_x[3:0]][pre_y[3:0]] <= pre_d;
  end

  logic [11:0] act_wr[$];
  logic [9:0]  act_rd[$];
  int          both_hi = 0;

  always @(negedge clk) begin
    if (wr_en) act_wr.push_back({x_loc, y_loc, wr_data});
    if (rd_en) act_rd.push_back({x_loc, y_loc});
    if (wr_en && rd_en) both_hi++;
  end

  // Reference model: snake as a coordinate queue (front = tail), grid of codes.
  logic [11:0] exp_wr[$];
  logic [9:0]  exp_rd[$];
  logic [9:0]  body_q[$];
  logic [1:0]  ref_grid [16][16];
  int          m_dir, m_lfsr, m_score;
  bit          m_over;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_next(input int v);
    if (v % 2 == 1) return (v / 2) ^ 'hB8;
    return v / 2;
  endfunction

  task automatic model_food();
    int x, y;
    for (int k = 0; k < 2000; k++) begin
      x = m_lfsr % 16;
      y = m_lfsr / 16;
      if (x != 0 && y != 0) begin
        exp_rd.push_back({5'(x), 5'(y)});
        if (ref_grid[x][y] == 2'b00) begin
          exp_wr.push_back({5'(x), 5'(y), 2'b01});
          ref_grid[x][y] = 2'b01;
          m_lfsr = lfsr_next(m_lfsr);
          return;
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic model_init();
    exp_wr.delete();
    exp_rd.delete();
    body_q.delete();
    for (int y = 1; y <= 15; y++)
      for (int x = 1; x <= 15; x++) begin
        exp_wr.push_back({5'(x), 5'(y), 2'b00});
        ref_grid[x][y] = 2'b00;
      end
    for (int x = 6; x <= 8; x++) begin
      exp_wr.push_back({5'(x), 5'd8, 2'b10});
      ref_grid[x][8] = 2'b10;
      body_q.push_back({5'(x), 5'd8});
    end
    m_dir = 1;
    m_lfsr = 'hA5;
    m_score = 0;
    m_over = 0;
    model_food();
  endtask

  task automatic model_tick(input int d);
    int nx, ny;
    logic [1:0] c;
    logic [9:0] hd, t;
    if (m_over) return;
    if (d != (m_dir + 2) % 4) m_dir = d;
    hd = body_q[body_q.size() - 1];
    nx = int'(hd[9:5]);
    ny = int'(hd[4:0]);
    if (m_dir == 0) ny = ny - 1;
    else if (m_dir == 1) nx = nx + 1;
    else if (m_dir == 2) ny = ny + 1;
    else nx = nx - 1;
    if (nx < 1 || nx > 15 || ny < 1 || ny > 15) begin
      m_over = 1;
      return;
    end
    exp_rd.push_back({5'(nx), 5'(ny)});
    c = ref_grid[nx][ny];
    if (c >= 2'b10) begin
      m_over = 1;
      return;
    end
    exp_wr.push_back({5'(nx), 5'(ny), 2'b10});
    ref_grid[nx][ny] = 2'b10;
    body_q.push_back({5'(nx), 5'(ny)});
    if (c == 2'b01 && m_score < 255) m_score++;
    if (c == 2'b00 || body_q.size() > MAX_LEN) begin
      t = body_q.pop_front();
      exp_wr.push_back({t, 2'b00});
      ref_grid[t[9:5]][t[4:0]] = 2'b00;
    end
    if (c == 2'b01) model_food();
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_wr_count"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++)
      chk({tag, "_wr"}, act_wr[i], exp_wr[i]);
    chk({tag, "_rd_count"}, act_rd.size(), exp_rd.size());
    for (int i = 0; i < act_rd.size() && i < exp_rd.size(); i++)
      chk({tag, "_rd"}, act_rd[i], exp_rd[i]);
    chk({tag, "_score"}, score, m_score);
    chk({tag, "_game_over"}, game_over, m_over);
    act_wr.delete();
    act_rd.delete();
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n;
    n = 0;
    while ((busy || wr_en || rd_en) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_settle"}, (n < budget), 1);
  endtask

  task automatic preload(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d);
    @(negedge clk);
    pre_x = x; pre_y = y; pre_d = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    ref_grid[x][y] = d;
  endtask

  task automatic reset_dut(input string tag);
    reset = 1'b0;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_rst_wr_en"}, wr_en, 0);
    chk({tag, "_rst_rd_en"}, rd_en, 0);
    chk({tag, "_rst_x"}, x_loc, 1);
    chk({tag, "_rst_y"}, y_loc, 1);
    chk({tag, "_rst_wr_data"}, wr_data, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    chk({tag, "_rst_game_over"}, game_over, 0);
    chk({tag, "_rst_score"}, score, 0);
    act_wr.delete();
    act_rd.delete();
    model_init();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    wait_quiet(3000, tag);
    check_logs(tag);
  endtask

  task automatic do_tick(input logic [1:0] d, input string tag);
    model_tick(int'(d));
    @(negedge clk);
    dir = d;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_quiet(3000, tag);
    check_logs(tag);
  endtask

  initial begin
    logic [9:0] first_rd;

    // Session A: init, plain move, food, wall, sticky game over.
    reset_dut("init_a");

    model_tick(1);
    @(negedge clk);
    dir = 2'd1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("move_busy", busy, 1);
      @(negedge clk);
    end
    chk("move_idle_after_4", busy, 0);
    first_rd = (act_rd.size() > 0) ? act_rd[0] : 10'd0;
    chk("move_read_9_8", first_rd, {5'd9, 5'd8});
    check_logs("move1");

    preload(5'd10, 5'd8, 2'b01);
    do_tick(2'd1, "eat");
    chk("eat_score_one", score, 1);

    for (int i = 0; i < 5; i++) do_tick(2'd1, "run_right");
    @(negedge clk);
    dir = 2'd1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("wall_game_over_next", game_over, 1);
    chk("wall_not_busy", busy, 0);
    model_tick(1);
    wait_quiet(10, "wall");
    check_logs("wall");
    do_tick(2'd0, "over_ignored");
    do_tick(2'd2, "over_ignored");

    // Session B: reverse direction ignored, busy tick dropped, random play.
    reset_dut("init_b");
    model_tick(3);
    @(negedge clk);
    dir = 2'd3;
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    wait_quiet(3000, "reverse");
    check_logs("reverse_drop");

    for (int i = 0; i < 40; i++) do_tick(2'($urandom_range(0, 3)), "random");

    // Session C: reset in the middle of the clear, then a body collision.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    reset_dut("restart");
    preload(5'd9, 5'd8, 2'b10);
    do_tick(2'd1, "collide");
    chk("collide_game_over", game_over, 1);

    chk("rd_wr_exclusive", both_hi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
